// File: rtl/vmu_adder_tree_if.sv
// Beat and result handshake bundle for the VMU adder tree.
// Upstream drives the beat side and the result-side ready through the
// master modport; the adder tree owns the slave modport.
interface vmu_adder_tree_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 8
);
  logic                                in_valid;
  logic                                in_ready;
  logic [1:0]                          in_mode;
  logic                                in_last;
  logic [LANES*DATA_WIDTH-1:0]         din;
  logic                                out_valid;
  logic                                out_ready;
  logic [1:0]                          out_mode;
  logic [DATA_WIDTH-1:0]               out_scalar;
  logic [(LANES/2)*DATA_WIDTH-1:0]     out_vec;
  logic                                out_ovf;

  modport master (
    output in_valid, in_mode, in_last, din, out_ready,
    input  in_ready, out_valid, out_mode, out_scalar, out_vec, out_ovf
  );

  modport slave (
    input  in_valid, in_mode, in_last, din, out_ready,
    output in_ready, out_valid, out_mode, out_scalar, out_vec, out_ovf
  );
endinterface

// File: rtl/vmu_adder_tree.sv
// Pipelined VMU lane adder tree.
// Stage 1 forms pairwise sums/differences, the following log2(LANES)-1
// stages reduce them (pairwise beats ride through untouched), and the
// final stage saturates or wraps, and folds ACCUM beats into a running
// accumulator. A single global stall freezes every stage while a result
// waits for the consumer.
module vmu_adder_tree #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 8,
  parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(LANES) + 8,
  parameter int SATURATE   = 1
) (
  input logic              clk,
  input logic              rst,
  vmu_adder_tree_if.slave  bus
);

  localparam int LG    = $clog2(LANES);
  localparam int HALF  = LANES / 2;
  localparam int SUM_W = DATA_WIDTH + LG;

  localparam logic [1:0] MODE_REDUCE   = 2'b00;
  localparam logic [1:0] MODE_PAIR_SUB = 2'b01;
  localparam logic [1:0] MODE_PAIR_ADD = 2'b10;
  localparam logic [1:0] MODE_ACCUM    = 2'b11;

  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef logic signed [SUM_W-1:0] node_t;

  function automatic node_t sext_lane(input logic [DATA_WIDTH-1:0] v);
    return {{LG{v[DATA_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] ext_acc(input node_t v);
    return {{(ACC_WIDTH-SUM_W){v[SUM_W-1]}}, v};
  endfunction

  // Returns {overflow, result}; overflow flags any value outside the
  // DATA_WIDTH signed range whether it is clamped or wrapped.
  function automatic logic [DATA_WIDTH:0] sat_fn(input logic signed [ACC_WIDTH-1:0] v);
    logic hi_ovf;
    logic lo_ovf;
    hi_ovf = (v > MAX_V);
    lo_ovf = (v < MIN_V);
    if (SATURATE != 0 && hi_ovf) return {1'b1, MAX_V[DATA_WIDTH-1:0]};
    if (SATURATE != 0 && lo_ovf) return {1'b1, MIN_V[DATA_WIDTH-1:0]};
    return {hi_ovf | lo_ovf, v[DATA_WIDTH-1:0]};
  endfunction

  logic                        adv;
  logic [LG-1:0]               vld_p;
  logic [1:0]                  mode_p [LG];
  logic [LG-1:0]               last_p;
  node_t                       tree_p   [LG][HALF];
  node_t                       tree_nxt [LG][HALF];

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum_acc;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic [DATA_WIDTH:0]         red_res;
  logic [DATA_WIDTH:0]         acc_res;
  logic [HALF*DATA_WIDTH-1:0]  vec_res;
  logic                        vec_ovf;

  assign adv          = bus.out_ready || !bus.out_valid;
  assign bus.in_ready = adv;

  // Next contents of every tree stage: pairwise front end, then one
  // reduction level per stage; pairwise beats pass their p[] along.
  always_comb begin
    for (int s = 0; s < LG; s++)
      for (int k = 0; k < HALF; k++)
        tree_nxt[s][k] = '0;
    for (int k = 0; k < HALF; k++) begin
      if (bus.in_mode == MODE_PAIR_SUB)
        tree_nxt[0][k] = sext_lane(bus.din[(2*k+1)*DATA_WIDTH +: DATA_WIDTH])
                       - sext_lane(bus.din[(2*k)*DATA_WIDTH +: DATA_WIDTH]);
      else
        tree_nxt[0][k] = sext_lane(bus.din[(2*k+1)*DATA_WIDTH +: DATA_WIDTH])
                       + sext_lane(bus.din[(2*k)*DATA_WIDTH +: DATA_WIDTH]);
    end
    for (int s = 1; s < LG; s++) begin
      if (mode_p[s-1] == MODE_PAIR_SUB || mode_p[s-1] == MODE_PAIR_ADD) begin
        for (int k = 0; k < HALF; k++)
          tree_nxt[s][k] = tree_p[s-1][k];
      end else begin
        for (int k = 0; k < (HALF >> s); k++)
          tree_nxt[s][k] = tree_p[s-1][2*k] + tree_p[s-1][2*k+1];
      end
    end
  end

  // Stage valids: the only pipeline state that reset clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p[0] <= bus.in_valid && bus.in_ready;
      for (int s = 1; s < LG; s++)
        vld_p[s] <= vld_p[s-1];
    end
  end

  // ---- stages 1..log2(LANES): tree data, mode and last advance together
  always_ff @(posedge clk) begin
    if (adv) begin
      mode_p[0] <= bus.in_mode;
      last_p[0] <= bus.in_last;
      for (int s = 1; s < LG; s++) begin
        mode_p[s] <= mode_p[s-1];
        last_p[s] <= last_p[s-1];
      end
      for (int s = 0; s < LG; s++)
        for (int k = 0; k < HALF; k++)
          tree_p[s][k] <= tree_nxt[s][k];
    end
  end

  assign sum_acc = ext_acc(tree_p[LG-1][0]);
  assign acc_sum = acc + sum_acc;

  // Range-limit the scalar, accumulated and pairwise candidates.
  always_comb begin
    logic [DATA_WIDTH:0] pr;
    pr      = '0;
    red_res = sat_fn(sum_acc);
    acc_res = sat_fn(acc_sum);
    vec_res = '0;
    vec_ovf = 1'b0;
    for (int k = 0; k < HALF; k++) begin
      pr = sat_fn(ext_acc(tree_p[LG-1][k]));
      vec_res[k*DATA_WIDTH +: DATA_WIDTH] = pr[DATA_WIDTH-1:0];
      vec_ovf = vec_ovf | pr[DATA_WIDTH];
    end
  end

  // ---- final stage: result register and ACCUM accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_mode   <= '0;
      bus.out_scalar <= '0;
      bus.out_vec    <= '0;
      bus.out_ovf    <= 1'b0;
      acc            <= '0;
    end else if (adv) begin
      bus.out_valid <= 1'b0;
      if (vld_p[LG-1]) begin
        case (mode_p[LG-1])
          MODE_REDUCE: begin
            bus.out_valid  <= 1'b1;
            bus.out_mode   <= MODE_REDUCE;
            bus.out_scalar <= red_res[DATA_WIDTH-1:0];
            bus.out_vec    <= '0;
            bus.out_ovf    <= red_res[DATA_WIDTH];
          end
          MODE_PAIR_SUB, MODE_PAIR_ADD: begin
            bus.out_valid  <= 1'b1;
            bus.out_mode   <= mode_p[LG-1];
            bus.out_scalar <= '0;
            bus.out_vec    <= vec_res;
            bus.out_ovf    <= vec_ovf;
          end
          default: begin
            if (last_p[LG-1]) begin
              bus.out_valid  <= 1'b1;
              bus.out_mode   <= MODE_ACCUM;
              bus.out_scalar <= acc_res[DATA_WIDTH-1:0];
              bus.out_vec    <= '0;
              bus.out_ovf    <= acc_res[DATA_WIDTH];
              acc            <= '0;
            end else begin
              acc <= acc_sum;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vmu_adder_tree.sv
// Directed bench for vmu_adder_tree: a saturating and a wrapping
// instance receive identical beats; results are collected at each
// accepted handshake and compared with hand-computed values.
module tb_vmu_adder_tree;

  localparam int DW = 16;
  localparam int L  = 8;
  localparam int H  = L / 2;

  typedef struct {
    logic [1:0]        mode;
    logic [DW-1:0]     scalar;
    logic [H*DW-1:0]   vec;
    logic              ovf;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  rec_t q_s[$];
  rec_t q_w[$];

  vmu_adder_tree_if #(.DATA_WIDTH(DW), .LANES(L)) bus_s ();
  vmu_adder_tree_if #(.DATA_WIDTH(DW), .LANES(L)) bus_w ();

  vmu_adder_tree #(.DATA_WIDTH(DW), .LANES(L), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s.slave));
  vmu_adder_tree #(.DATA_WIDTH(DW), .LANES(L), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w.slave));

  always #5 clk = ~clk;

  // Record each result at the negedge before its accepting edge.
  always @(negedge clk) begin
    if (!rst && bus_s.out_valid && bus_s.out_ready)
      q_s.push_back('{bus_s.out_mode, bus_s.out_scalar, bus_s.out_vec, bus_s.out_ovf});
    if (!rst && bus_w.out_valid && bus_w.out_ready)
      q_w.push_back('{bus_w.out_mode, bus_w.out_scalar, bus_w.out_vec, bus_w.out_ovf});
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [L*DW-1:0] pack(input int v0, input int v1, input int v2,
                                           input int v3, input int v4, input int v5,
                                           input int v6, input int v7);
    logic [L*DW-1:0] r;
    r = {v7[DW-1:0], v6[DW-1:0], v5[DW-1:0], v4[DW-1:0],
         v3[DW-1:0], v2[DW-1:0], v1[DW-1:0], v0[DW-1:0]};
    return r;
  endfunction

  function automatic logic [L*DW-1:0] fill(input int v);
    return pack(v, v, v, v, v, v, v, v);
  endfunction

  function automatic longint vel(input rec_t r, input int k);
    return longint'($signed(r.vec[k*DW +: DW]));
  endfunction

  task automatic set_in(input logic v, input logic [1:0] m, input logic last,
                        input logic [L*DW-1:0] d);
    bus_s.in_valid = v; bus_s.in_mode = m; bus_s.in_last = last; bus_s.din = d;
    bus_w.in_valid = v; bus_w.in_mode = m; bus_w.in_last = last; bus_w.din = d;
  endtask

  task automatic set_ready(input logic r);
    bus_s.out_ready = r;
    bus_w.out_ready = r;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] m, input logic last, input logic [L*DW-1:0] d);
    logic ok;
    logic done;
    done = 1'b0;
    set_in(1'b1, m, last, d);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      ok = bus_s.in_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
    end
    check("send_accept", done, 1);
  endtask

  task automatic idle();
    set_in(1'b0, 2'b00, 1'b0, '0);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_s.delete();
    q_w.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    rst = 1'b1;
    set_ready(1'b1);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid",  bus_s.out_valid, 0);
    check("rst_out_scalar", bus_s.out_scalar, 0);
    check("rst_out_vec",    bus_s.out_vec, 0);
    check("rst_out_mode",   bus_s.out_mode, 0);
    check("rst_out_ovf",    bus_s.out_ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // REDUCE 1..8 = 36; latency counted from the presenting cycle
    set_in(1'b1, 2'b00, 1'b0, pack(1, 2, 3, 4, 5, 6, 7, 8));
    @(negedge clk);
    check("in_ready_idle", bus_s.in_ready, 1);
    @(posedge clk); #1;
    idle();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (bus_s.out_valid) break;
    end
    check("reduce_latency", n, 4);
    drain(6);
    check("reduce_count", q_s.size(), 1);
    if (q_s.size() >= 1) begin
      check("reduce_scalar", $signed(q_s[0].scalar), 36);
      check("reduce_vec",    q_s[0].vec, 0);
      check("reduce_ovf",    q_s[0].ovf, 0);
      check("reduce_mode",   q_s[0].mode, 0);
    end
    clear_q();

    // PAIR_SUB then PAIR_ADD on {5,3,0,7,-2,-2,100,-100}
    send(2'b01, 1'b0, pack(5, 3, 0, 7, -2, -2, 100, -100));
    send(2'b10, 1'b0, pack(5, 3, 0, 7, -2, -2, 100, -100));
    idle();
    drain(8);
    check("pair_count", q_s.size(), 2);
    if (q_s.size() >= 2) begin
      check("psub_k0", vel(q_s[0], 0), -2);
      check("psub_k1", vel(q_s[0], 1), 7);
      check("psub_k2", vel(q_s[0], 2), 0);
      check("psub_k3", vel(q_s[0], 3), -200);
      check("psub_scalar", q_s[0].scalar, 0);
      check("psub_mode", q_s[0].mode, 1);
      check("psub_ovf", q_s[0].ovf, 0);
      check("padd_k0", vel(q_s[1], 0), 8);
      check("padd_k1", vel(q_s[1], 1), 7);
      check("padd_k2", vel(q_s[1], 2), -4);
      check("padd_k3", vel(q_s[1], 3), 0);
      check("padd_mode", q_s[1].mode, 2);
    end
    clear_q();

    // Range limits: 8*32767 = 262136 (low 16 bits 0xFFF8 = -8 when wrapped);
    // 0 - (-32768) = 32768 (wraps to -32768)
    send(2'b00, 1'b0, fill(32767));
    send(2'b01, 1'b0, pack(-32768, 0, 0, 0, 0, 0, 0, 0));
    idle();
    drain(8);
    check("sat_count", q_s.size(), 2);
    check("wrap_count", q_w.size(), 2);
    if (q_s.size() >= 2 && q_w.size() >= 2) begin
      check("sat_red_scalar",  $signed(q_s[0].scalar), 32767);
      check("sat_red_ovf",     q_s[0].ovf, 1);
      check("sat_psub_k0",     vel(q_s[1], 0), 32767);
      check("sat_psub_k1",     vel(q_s[1], 1), 0);
      check("sat_psub_ovf",    q_s[1].ovf, 1);
      check("wrap_red_scalar", $signed(q_w[0].scalar), -8);
      check("wrap_red_ovf",    q_w[0].ovf, 1);
      check("wrap_psub_k0",    vel(q_w[1], 0), -32768);
      check("wrap_psub_ovf",   q_w[1].ovf, 1);
    end
    clear_q();

    // ACCUM, three beats of all ones -> 24
    send(2'b11, 1'b0, fill(1));
    send(2'b11, 1'b0, fill(1));
    send(2'b11, 1'b1, fill(1));
    idle();
    drain(8);
    check("accum_count", q_s.size(), 1);
    if (q_s.size() >= 1) begin
      check("accum_scalar", $signed(q_s[0].scalar), 24);
      check("accum_mode",   q_s[0].mode, 3);
      check("accum_vec",    q_s[0].vec, 0);
      check("accum_ovf",    q_s[0].ovf, 0);
    end
    clear_q();

    // ACCUM group with a REDUCE beat interleaved
    send(2'b11, 1'b0, fill(1));
    send(2'b00, 1'b0, pack(1, 2, 3, 4, 5, 6, 7, 8));
    send(2'b11, 1'b0, fill(1));
    send(2'b11, 1'b1, fill(1));
    idle();
    drain(8);
    check("ilv_count", q_s.size(), 2);
    if (q_s.size() >= 2) begin
      check("ilv_first_mode",    q_s[0].mode, 0);
      check("ilv_first_scalar",  $signed(q_s[0].scalar), 36);
      check("ilv_second_mode",   q_s[1].mode, 3);
      check("ilv_second_scalar", $signed(q_s[1].scalar), 24);
    end
    clear_q();

    // Backpressure: six REDUCE beats, consumer stalls three cycles
    fork
      begin
        for (int j = 1; j <= 6; j++) send(2'b00, 1'b0, fill(j));
        idle();
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
          @(posedge clk); #1;
          if (bus_s.out_valid) seen = 1'b1;
        end
        check("stall_seen", seen, 1);
        set_ready(1'b0);
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready",  bus_s.in_ready, 0);
          check("stall_out_valid", bus_s.out_valid, 1);
          check("stall_hold",      $signed(bus_s.out_scalar), 8);
        end
        @(posedge clk); #1;
        set_ready(1'b1);
      end
    join
    drain(12);
    check("bp_count", q_s.size(), 6);
    for (int i = 0; i < 6 && i < q_s.size(); i++)
      check("bp_order", $signed(q_s[i].scalar), 8 * (i + 1));
    clear_q();

    // Reset in the middle of an ACCUM group
    send(2'b00, 1'b0, pack(1, 2, 3, 4, 5, 6, 7, 8));
    send(2'b11, 1'b0, fill(1));
    send(2'b11, 1'b0, fill(1));
    idle();
    drain(6);
    check("pre_rst_scalar", $signed(bus_s.out_scalar), 36);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
    @(negedge clk);
    check("mid_rst_valid",  bus_s.out_valid, 0);
    check("mid_rst_scalar", bus_s.out_scalar, 0);
    check("mid_rst_vec",    bus_s.out_vec, 0);
    check("mid_rst_mode",   bus_s.out_mode, 0);
    check("mid_rst_ovf",    bus_s.out_ovf, 0);
    @(posedge clk); #1;
    send(2'b11, 1'b1, fill(1));
    idle();
    drain(8);
    check("post_rst_count", q_s.size(), 1);
    if (q_s.size() >= 1)
      check("post_rst_scalar", $signed(q_s[0].scalar), 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
